// File: rtl/instr_ctrl_pkg.sv
// Shared types for the multi-cycle instruction controller: opcodes, FSM states,
// instruction classes and the IR field positions.
package instr_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_ORR  = 4'h4,
    OP_MOV  = 4'h5,
    OP_MUL  = 4'h6,
    OP_LDR  = 4'h7,
    OP_STR  = 4'h8,
    OP_B    = 4'h9,
    OP_BEQ  = 4'hA,
    OP_RSVB = 4'hB,
    OP_RSVC = 4'hC,
    OP_RSVD = 4'hD,
    OP_RSVE = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_ALU  = 3'd1,
    CL_LDR  = 3'd2,
    CL_STR  = 3'd3,
    CL_BR   = 3'd4,
    CL_BEQ  = 3'd5,
    CL_HALT = 3'd6
  } iclass_t;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RN_HI  = 23;
  localparam int RN_LO  = 20;
  localparam int RM_HI  = 19;
  localparam int RM_LO  = 16;
  localparam int RS_HI  = 15;
  localparam int RS_LO  = 12;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef struct packed {
    state_t      state;
    logic        z;
    logic        illegal;
    logic [31:0] ir;
  } dbg_t;

endpackage

// File: rtl/instr_ctrl_if.sv
// Operand/writeback bus between the controller (master) and the register
// file / IMEM / ALU side (slave).
interface instr_ctrl_if;

  logic [31:0] IMEM_instr;
  logic [3:0]  PC_out;
  logic        ALU_Z;
  logic [3:0]  IR_ARn;
  logic [3:0]  IR_ARs;
  logic [3:0]  IR_ARm;
  logic [3:0]  mux_ARd_or_15;
  logic        CNTRL_write_en_ARd;
  logic [3:0]  PC_next;
  logic [3:0]  CNTRL_ALU_op;
  logic        CNTRL_sel_DMEM;
  logic        CNTRL_DMEM_we;
  logic        halted;
  logic        illegal;

  // No valid/ready pair: the bus runs on a fixed per-state schedule and the
  // write enable / DMEM strobe are the only qualifiers; addresses are valid
  // from DECODE through WB and the slave must accept every strobe it sees.
  modport master (
    input  IMEM_instr, PC_out, ALU_Z,
    output IR_ARn, IR_ARs, IR_ARm, mux_ARd_or_15, CNTRL_write_en_ARd,
           PC_next, CNTRL_ALU_op, CNTRL_sel_DMEM, CNTRL_DMEM_we, halted, illegal
  );

  modport slave (
    output IMEM_instr, PC_out, ALU_Z,
    input  IR_ARn, IR_ARs, IR_ARm, mux_ARd_or_15, CNTRL_write_en_ARd,
           PC_next, CNTRL_ALU_op, CNTRL_sel_DMEM, CNTRL_DMEM_we, halted, illegal
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational opcode decode: instruction class, legality, ALU operation and
// whether the instruction updates the Z flag.
module instr_decode
  import instr_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output iclass_t    iclass,
  output logic       legal,
  output logic [3:0] alu_op,
  output logic       z_update
);

  always_comb begin
    iclass   = CL_NOP;
    legal    = 1'b1;
    z_update = 1'b0;
    alu_op   = op;
    case (opcode_t'(op))
      OP_NOP: iclass = CL_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV, OP_MUL: begin
        iclass   = CL_ALU;
        z_update = 1'b1;
      end
      OP_LDR:  iclass = CL_LDR;
      OP_STR:  iclass = CL_STR;
      OP_B:    iclass = CL_BR;
      OP_BEQ:  iclass = CL_BEQ;
      OP_HALT: iclass = CL_HALT;
      // Reserved opcodes run as NOP; the caller records them as illegal.
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller: owns IR, Z and the sticky
// status flags and drives all register-file addressing and PC_next.
module instr_ctrl
  import instr_ctrl_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  instr_ctrl_if.master bus,
  output dbg_t        dbg
);

  state_t      state;
  logic [31:0] ir;
  logic        z_flag;
  logic        illegal_q;

  iclass_t     iclass;
  logic        legal;
  logic [3:0]  alu_op;
  logic        z_update;
  logic [3:0]  imm;
  logic [3:0]  pc_next;

  instr_decode u_decode (
    .op       (ir[OP_HI:OP_LO]),
    .iclass   (iclass),
    .legal    (legal),
    .alu_op   (alu_op),
    .z_update (z_update)
  );

  assign imm = ir[IMM_HI:IMM_LO];

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state     <= S_FETCH;
      ir        <= '0;
      z_flag    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= bus.IMEM_instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal) begin
            illegal_q <= 1'b1;
            state     <= S_FETCH;
          end else begin
            case (iclass)
              CL_NOP:  state <= S_FETCH;
              CL_HALT: state <= S_HALT;
              default: state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          case (iclass)
            CL_LDR, CL_STR: state <= S_MEM;
            CL_ALU:         state <= S_WB;
            default:        state <= S_FETCH;
          endcase
        end
        S_MEM: state <= (iclass == CL_LDR) ? S_WB : S_FETCH;
        S_WB: begin
          if (z_update) z_flag <= bus.ALU_Z;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset is folded into the outputs so an aborted WB or MEM cycle never
  // commits, and R15 is loaded with 0 while reset is held.
  always_comb begin
    pc_next = bus.PC_out;
    if (!RESET_N) begin
      pc_next = 4'd0;
    end else begin
      case (state)
        S_FETCH: pc_next = bus.PC_out + 4'd1;
        S_EXEC: begin
          if (iclass == CL_BR) pc_next = imm;
          else if (iclass == CL_BEQ) pc_next = z_flag ? imm : bus.PC_out;
        end
        default: pc_next = bus.PC_out;
      endcase
    end
  end

  assign bus.IR_ARn             = ir[RN_HI:RN_LO];
  assign bus.IR_ARs             = ir[RS_HI:RS_LO];
  assign bus.IR_ARm             = ir[RM_HI:RM_LO];
  assign bus.mux_ARd_or_15      = ir[RD_HI:RD_LO];
  assign bus.CNTRL_ALU_op       = alu_op;
  assign bus.PC_next            = pc_next;
  assign bus.CNTRL_write_en_ARd = RESET_N && (state == S_WB);
  assign bus.CNTRL_DMEM_we      = RESET_N && (state == S_MEM) && (iclass == CL_STR);
  assign bus.CNTRL_sel_DMEM     = (state == S_WB) && (iclass == CL_LDR);
  assign bus.halted             = RESET_N && (state == S_HALT);
  assign bus.illegal            = illegal_q;

  assign dbg.state   = state;
  assign dbg.z       = z_flag;
  assign dbg.illegal = illegal_q;
  assign dbg.ir      = ir;

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed per-cycle vectors for instr_ctrl: the bench plays register file,
// IMEM and ALU by driving PC_out/IMEM_instr/ALU_Z with hand-computed values.
module tb_instr_ctrl;
  import instr_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLOCK_50;
  logic RESET_N;
  dbg_t dbg;

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  instr_ctrl_if bus ();

  instr_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus),
    .dbg      (dbg)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  pc;
    logic        z_in;
    state_t      st;
    logic        we;
    logic        dwe;
    logic        sel;
    logic [3:0]  pcn;
    logic        halt;
    logic        ill;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  op;
  } vec_t;

  localparam state_t F = S_FETCH;
  localparam state_t D = S_DECODE;
  localparam state_t E = S_EXEC;
  localparam state_t M = S_MEM;
  localparam state_t W = S_WB;
  localparam state_t H = S_HALT;
  localparam logic [31:0] J = 32'hB0FF_FFFF;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] ins, input logic [3:0] pc,
                              input logic z, input state_t st, input logic we, input logic dwe,
                              input logic sel, input logic [3:0] pcn, input logic halt,
                              input logic ill, input logic [3:0] rd, input logic [3:0] rn,
                              input logic [3:0] op);
    vec_t v;
    v.rst_n = r;  v.instr = ins; v.pc = pc;   v.z_in = z;  v.st = st;
    v.we = we;    v.dwe = dwe;   v.sel = sel; v.pcn = pcn; v.halt = halt;
    v.ill = ill;  v.rd = rd;     v.rn = rn;   v.op = op;
    return v;
  endfunction

  // ---------------- driver + checker ----------------
  task automatic apply(input vec_t v, input string tag);
    logic ok;
    RESET_N        = v.rst_n;
    bus.IMEM_instr = v.instr;
    bus.PC_out     = v.pc;
    bus.ALU_Z      = v.z_in;
    #1;
    n_vec++;
    ok = (dbg.state == v.st) && (bus.CNTRL_write_en_ARd == v.we) &&
         (bus.CNTRL_DMEM_we == v.dwe) && (bus.CNTRL_sel_DMEM == v.sel) &&
         (bus.PC_next == v.pcn) && (bus.halted == v.halt) && (bus.illegal == v.ill);
    // IR-derived outputs still show the previous instruction during FETCH.
    if (v.st != S_FETCH)
      ok = ok && (bus.mux_ARd_or_15 == v.rd) && (bus.IR_ARn == v.rn) && (bus.CNTRL_ALU_op == v.op);
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got st=%0d we=%b dwe=%b sel=%b pcn=%h halt=%b ill=%b rd=%h rn=%h op=%h, want st=%0d we=%b dwe=%b sel=%b pcn=%h halt=%b ill=%b rd=%h rn=%h op=%h",
               tag, dbg.state, bus.CNTRL_write_en_ARd, bus.CNTRL_DMEM_we, bus.CNTRL_sel_DMEM,
               bus.PC_next, bus.halted, bus.illegal, bus.mux_ARd_or_15, bus.IR_ARn, bus.CNTRL_ALU_op,
               v.st, v.we, v.dwe, v.sel, v.pcn, v.halt, v.ill, v.rd, v.rn, v.op);
    end
    if (bus.CNTRL_write_en_ARd && bus.CNTRL_DMEM_we) begin
      n_miss++;
      $display("FAIL %s_excl: we=%b dwe=%b both set, want at most one", tag,
               bus.CNTRL_write_en_ARd, bus.CNTRL_DMEM_we);
    end
    @(negedge CLOCK_50);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[33];

  initial begin
    RESET_N        = 1'b0;
    bus.IMEM_instr = '0;
    bus.PC_out     = 4'hA;
    bus.ALU_Z      = 1'b0;
    @(negedge CLOCK_50);
    // Second reset cycle: R15 still garbage, PC_next must be 0.
    apply(mk(0, J, 4'hA, 0, F, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0), "reset");

    //        rst instr          pc  z  st we dwe sel pcn halt ill rd rn op
    tbl[0]  = mk(1, 32'h1123_0000, 0, 0, F, 0, 0, 0, 1,  0, 0, 0, 0, 0);  // ADD R1,R2,R3
    tbl[1]  = mk(1, J,             1, 0, D, 0, 0, 0, 1,  0, 0, 1, 2, 1);
    tbl[2]  = mk(1, J,             1, 0, E, 0, 0, 0, 1,  0, 0, 1, 2, 1);
    tbl[3]  = mk(1, J,             1, 0, W, 1, 0, 0, 1,  0, 0, 1, 2, 1);
    tbl[4]  = mk(1, 32'h7420_0000, 1, 0, F, 0, 0, 0, 2,  0, 0, 0, 0, 0);  // LDR R4,[R2]
    tbl[5]  = mk(1, J,             2, 0, D, 0, 0, 0, 2,  0, 0, 4, 2, 7);
    tbl[6]  = mk(1, J,             2, 0, E, 0, 0, 0, 2,  0, 0, 4, 2, 7);
    tbl[7]  = mk(1, J,             2, 0, M, 0, 0, 0, 2,  0, 0, 4, 2, 7);
    tbl[8]  = mk(1, J,             2, 1, W, 1, 0, 1, 2,  0, 0, 4, 2, 7);  // Z must ignore LDR
    tbl[9]  = mk(1, 32'h8420_0000, 2, 0, F, 0, 0, 0, 3,  0, 0, 0, 0, 0);  // STR [R2]=R4
    tbl[10] = mk(1, J,             3, 0, D, 0, 0, 0, 3,  0, 0, 4, 2, 8);
    tbl[11] = mk(1, J,             3, 0, E, 0, 0, 0, 3,  0, 0, 4, 2, 8);
    tbl[12] = mk(1, J,             3, 0, M, 0, 1, 0, 3,  0, 0, 4, 2, 8);
    tbl[13] = mk(1, 32'hA000_0009, 3, 0, F, 0, 0, 0, 4,  0, 0, 0, 0, 0);  // BEQ 9, Z=0
    tbl[14] = mk(1, J,             4, 0, D, 0, 0, 0, 4,  0, 0, 0, 0, 4'hA);
    tbl[15] = mk(1, J,             4, 0, E, 0, 0, 0, 4,  0, 0, 0, 0, 4'hA);
    tbl[16] = mk(1, 32'h2511_0000, 4, 0, F, 0, 0, 0, 5,  0, 0, 0, 0, 0);  // SUB R5,R1,R1
    tbl[17] = mk(1, J,             5, 0, D, 0, 0, 0, 5,  0, 0, 5, 1, 2);
    tbl[18] = mk(1, J,             5, 0, E, 0, 0, 0, 5,  0, 0, 5, 1, 2);
    tbl[19] = mk(1, J,             5, 1, W, 1, 0, 0, 5,  0, 0, 5, 1, 2);
    tbl[20] = mk(1, 32'hA000_0009, 5, 0, F, 0, 0, 0, 6,  0, 0, 0, 0, 0);  // BEQ 9, Z=1
    tbl[21] = mk(1, J,             6, 0, D, 0, 0, 0, 6,  0, 0, 0, 0, 4'hA);
    tbl[22] = mk(1, J,             6, 0, E, 0, 0, 0, 9,  0, 0, 0, 0, 4'hA);
    tbl[23] = mk(1, 32'hC000_0000, 9, 0, F, 0, 0, 0, 10, 0, 0, 0, 0, 0);  // illegal 0xC
    tbl[24] = mk(1, J,            10, 0, D, 0, 0, 0, 10, 0, 0, 0, 0, 4'hC);
    tbl[25] = mk(1, 32'h0000_0000,10, 0, F, 0, 0, 0, 11, 0, 1, 0, 0, 0);  // NOP
    tbl[26] = mk(1, J,            11, 0, D, 0, 0, 0, 11, 0, 1, 0, 0, 0);
    tbl[27] = mk(1, 32'h9000_000F,11, 0, F, 0, 0, 0, 12, 0, 1, 0, 0, 0);  // B 15
    tbl[28] = mk(1, J,            12, 0, D, 0, 0, 0, 12, 0, 1, 0, 0, 9);
    tbl[29] = mk(1, J,            12, 0, E, 0, 0, 0, 15, 0, 1, 0, 0, 9);
    tbl[30] = mk(1, 32'h9000_0000,15, 0, F, 0, 0, 0, 0,  0, 1, 0, 0, 0);  // B 0 at 15, inc wraps
    tbl[31] = mk(1, J,             0, 0, D, 0, 0, 0, 0,  0, 1, 0, 0, 9);
    tbl[32] = mk(1, J,             0, 0, E, 0, 0, 0, 0,  0, 1, 0, 0, 9);

    for (int i = 0; i < 33; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Reset lands during WB of ADD R1: no write, restart at PC 0.
    apply(mk(0, J,             0, 0, F, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rst_a0");
    apply(mk(0, J,             0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_a1");
    apply(mk(1, 32'h1123_0000, 0, 0, F, 0, 0, 0, 1, 0, 0, 0, 0, 0), "wbrst_f");
    apply(mk(1, J,             1, 0, D, 0, 0, 0, 1, 0, 0, 1, 2, 1), "wbrst_d");
    apply(mk(1, J,             1, 0, E, 0, 0, 0, 1, 0, 0, 1, 2, 1), "wbrst_e");
    apply(mk(0, J,             1, 0, W, 0, 0, 0, 0, 0, 0, 1, 2, 1), "wbrst_w");
    apply(mk(0, J,             0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wbrst_hold");
    apply(mk(1, 32'h1123_0000, 0, 0, F, 0, 0, 0, 1, 0, 0, 0, 0, 0), "restart_f");
    apply(mk(1, J,             1, 0, D, 0, 0, 0, 1, 0, 0, 1, 2, 1), "restart_d");
    apply(mk(1, J,             1, 0, E, 0, 0, 0, 1, 0, 0, 1, 2, 1), "restart_e");
    apply(mk(1, J,             1, 0, W, 1, 0, 0, 1, 0, 0, 1, 2, 1), "restart_w");

    // Reset lands during MEM of STR: no DMEM strobe.
    apply(mk(1, 32'h8420_0000, 1, 0, F, 0, 0, 0, 2, 0, 0, 0, 0, 0), "memrst_f");
    apply(mk(1, J,             2, 0, D, 0, 0, 0, 2, 0, 0, 4, 2, 8), "memrst_d");
    apply(mk(1, J,             2, 0, E, 0, 0, 0, 2, 0, 0, 4, 2, 8), "memrst_e");
    apply(mk(0, J,             2, 0, M, 0, 0, 0, 0, 0, 0, 4, 2, 8), "memrst_m");
    apply(mk(0, J,             0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0, 0), "memrst_hold");

    // HALT: 2 cycles then stall with PC held.
    apply(mk(1, 32'hF000_0000, 0, 0, F, 0, 0, 0, 1, 0, 0, 0, 0, 0), "halt_f");
    apply(mk(1, J,             1, 0, D, 0, 0, 0, 1, 0, 0, 0, 0, 4'hF), "halt_d");
    for (int k = 0; k < 4; k++)
      apply(mk(1, J, 1, 0, H, 0, 0, 0, 1, 1, 0, 0, 0, 4'hF), $sformatf("halt_hold%0d", k));
    apply(mk(0, J,             1, 0, H, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF), "halt_rst");
    apply(mk(1, 32'h0000_0000, 0, 0, F, 0, 0, 0, 1, 0, 0, 0, 0, 0), "halt_exit");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_ctrl.md
# instr_ctrl

Multi-cycle control unit that initiates every register-file access in the processor: fetches a 32-bit instruction from IMEM at `PC_out`, drives the register-file read addresses, write address, write enable and `PC_next`, and sequences ALU/DMEM control through FETCH/DECODE/EXEC/MEM/WB. It sits opposite the register file on the operand/writeback interface. It also owns the Z flag and halt/illegal status.

## Interface
- No parameters. Instruction width 32, register address 4, PC 4, all fixed.
- `CLOCK_50` in 1: sole clock, rising edge.
- `RESET_N` in 1: synchronous, active-low reset.
- `IMEM_instr` in 32: instruction at `PC_out`, combinational.
- `PC_out` in 4: current PC from the register file (R15).
- `ALU_Z` in 1: ALU zero result, valid in WB.
- `IR_ARn`, `IR_ARs`, `IR_ARm` out 4: read addresses, IR[23:20], IR[15:12], IR[19:16].
- `mux_ARd_or_15` out 4: write/Rd-read address, IR[27:24].
- `CNTRL_write_en_ARd` out 1: register write enable.
- `PC_next` out 4: value written to R15 every cycle without an R15 write.
- `CNTRL_ALU_op` out 4: ALU operation, equal to the opcode.
- `CNTRL_sel_DMEM` out 1: 1 selects DMEM data for writeback, 0 selects the ALU result.
- `CNTRL_DMEM_we` out 1: DMEM write strobe.
- `halted` out 1: HALT reached.
- `illegal` out 1: sticky undefined-opcode flag.

## Operation
- IR[31:28] opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 MOV (Rm), 6 MUL (Rm*Rs), 7 LDR Rd=[Rn], 8 STR [Rn]=Rd, 9 B, A BEQ, F HALT. Branch target is IR[3:0]. Opcodes B–E are illegal: set `illegal` and execute as NOP.
- States are FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - IR <= `IMEM_instr`.
  - `PC_next` = `PC_out`+1, 4-bit modulo, so 15 wraps to 0.
  - Next state DECODE.
- DECODE: addresses are driven from IR. The register file registers operands at this edge.
  - NOP/illegal -> FETCH.
  - HALT -> HALT.
  - Otherwise -> EXEC.
- EXEC: ALU op is driven.
  - B: `PC_next` = IR[3:0], then FETCH.
  - BEQ: `PC_next` = IR[3:0] if Z=1, else `PC_out`; then FETCH.
  - LDR/STR -> MEM; the ALU passes Rn as the DMEM address.
  - ALU ops -> WB.
- MEM:
  - STR: `CNTRL_DMEM_we`=1 for exactly one cycle, then FETCH.
  - LDR -> WB.
- WB:
  - `CNTRL_write_en_ARd`=1.
  - `CNTRL_sel_DMEM`=1 for LDR, 0 otherwise.
  - Z <= `ALU_Z` for opcodes 1–6.
  - Next state FETCH.
- HALT: `halted`=1; the state is held until reset.
- Every cycle except FETCH and branch EXEC: `PC_next` = `PC_out` (hold).
- An ALU/LDR write with Rd=15 overrides `PC_next` in the register file. The next FETCH then uses the written PC.
- IR, and therefore all addresses, stay stable from DECODE through WB.

## Timing
- Reset (`RESET_N`=0 at an edge):
  - State becomes FETCH; IR, Z and `illegal` clear to 0.
  - `CNTRL_write_en_ARd`=0, `CNTRL_DMEM_we`=0, `PC_next`=0, `halted`=0.
  - Outputs are combinational from state+IR, so they read these values while reset is held.
  - PC reaches 0 after one reset edge. Reset must be held for at least 2 cycles.
- Cycles per instruction: NOP/illegal 2, HALT 2 then stall, B/BEQ 3, ALU 4, STR 4, LDR 5.
- Reset asserted in any state, including WB or MEM, aborts the instruction: no write or DMEM strobe at that edge, and the next active cycle is FETCH of address 0.
- Only one of `CNTRL_write_en_ARd` and `CNTRL_DMEM_we` is ever asserted in a given cycle.

## Structure
- `instr_ctrl_pkg` holds:
  - the opcode enum (4 bits);
  - the state enum;
  - field localparams (OP 31:28, RD 27:24, RN 23:20, RM 19:16, RS 15:12, IMM 3:0).
- One combinational sub-module, `instr_decode` (IR -> class, legality, ALU op). The FSM, IR, Z and sticky flags live in `instr_ctrl`.

## Test plan
- Hold reset 2 cycles with R15=X -> `PC_out`=0. The first FETCH latches IMEM[0], and `PC_next`=1 in that cycle.
- ADD R1,R2,R3 with R2=5, R3=7 -> write enable only in cycle 4 (WB) to address 1 with data 12. Z=0 afterwards; PC=1.
- LDR R4,[R2] with DMEM[5]=0xDEAD -> 5 cycles; R4=0xDEAD; `CNTRL_sel_DMEM`=1 only in WB. STR -> exactly one `CNTRL_DMEM_we` pulse.
- SUB giving 0, then BEQ 9 -> PC=9. With Z=0, BEQ 9 -> PC = branch address+1. B 0 placed at PC=15 -> PC=0; an increment from PC=15 wraps to 0.
- Opcode 0xC -> `illegal`=1, no write, 2 cycles, then it continues. HALT -> `halted`=1 and `PC_next`=`PC_out` indefinitely.
- Reset asserted during WB of ADD R1 -> R1 is unchanged, all enables are 0, and the run restarts at PC 0.
